// File: rtl/nibble_rx_pkg.sv
// Shared types and sizing helpers for the nibble serial receiver.
// Optional feature macro: NIBBLE_RX_PARITY_EN (adds an even-parity bit).
package nibble_rx_pkg;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 16;
    localparam int unsigned DEFAULT_WIDTH        = 4;

    // Receiver states; PARITY is only reachable with NIBBLE_RX_PARITY_EN.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } rx_state_e;

    // Bit-period counter width; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned clks_per_bit);
        return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
    endfunction

    // Bit-index width, wide enough to hold WIDTH-1.
    function automatic int unsigned idx_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/nibble_rx_loader_if.sv
// Serial-in / load-register-out bundle for nibble_rx_loader.
interface nibble_rx_loader_if #(
    parameter int unsigned WIDTH = 4
);
    logic             SI;
    logic             EN;
    logic [WIDTH-1:0] Q;
    logic             L;
    logic             BUSY;
    logic             FE;

    // Frame source side (drives the line and enable).
    modport master (
        output SI, EN,
        input  Q, L, BUSY, FE
    );

    // Receiver side.
    modport slave (
        input  SI, EN,
        output Q, L, BUSY, FE
    );
endinterface

// File: rtl/nibble_rx_sync.sv
// Two-flop synchronizer for the idle-high serial line; resets to 1.
module nibble_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;

    // Both stages reset high so reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/nibble_rx_loader.sv
// UART-style serial receiver that loads a WIDTH-bit register (Q + strobe L).
// Frame: start, WIDTH data bits LSB first, [even parity], stop.
// Optional: define NIBBLE_RX_PARITY_EN to insert the parity bit.
// CLKS_PER_BIT must be even and at least 4.
module nibble_rx_loader
    import nibble_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned WIDTH        = DEFAULT_WIDTH
) (
    input  logic             C,
    input  logic             aRn,
    nibble_rx_loader_if.slave bus
);
    localparam int unsigned CNT_W = cnt_width(CLKS_PER_BIT);
    localparam int unsigned IDX_W = idx_width(WIDTH);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(WIDTH - 1);

    logic             s;
    logic             s_prev;
    logic             fall_c;

    rx_state_e        state,   state_n;
    logic [CNT_W-1:0] cnt,     cnt_n;
    logic [IDX_W-1:0] idx,     idx_n;
    logic [WIDTH-1:0] shift,   shift_n;
    logic [WIDTH-1:0] q_r,     q_n;
    logic             l_r,     l_n;
    logic             fe_r,    fe_n;
    logic             busy_r;
`ifdef NIBBLE_RX_PARITY_EN
    logic             par_err, par_err_n;
`endif

    nibble_rx_sync u_sync (
        .clk   (C),
        .rst_n (aRn),
        .d     (bus.SI),
        .q     (s)
    );

    assign fall_c = s_prev & ~s;

    // Next-state, datapath and strobe decode.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shift_n = shift;
        q_n     = q_r;
        l_n     = 1'b0;
        fe_n    = 1'b0;
`ifdef NIBBLE_RX_PARITY_EN
        par_err_n = par_err;
`endif
        case (state)
            IDLE: begin
                if (bus.EN && fall_c) begin
                    state_n = START;
                    cnt_n   = '0;
                    idx_n   = '0;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n   = '0;
                    state_n = s ? IDLE : DATA;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == FULL_LAST) begin
                    cnt_n            = '0;
                    shift_n          = shift >> 1;
                    shift_n[WIDTH-1] = s;
                    if (idx == IDX_LAST) begin
                        idx_n = '0;
`ifdef NIBBLE_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
`ifdef NIBBLE_RX_PARITY_EN
            PARITY: begin
                if (cnt == FULL_LAST) begin
                    cnt_n     = '0;
                    par_err_n = s ^ (^shift);
                    state_n   = STOP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
`endif
            STOP: begin
                if (cnt == FULL_LAST) begin
                    cnt_n = '0;
`ifdef NIBBLE_RX_PARITY_EN
                    if (par_err) begin
                        fe_n    = 1'b1;
                        state_n = s ? IDLE : WAIT_IDLE;
                    end else
`endif
                    if (s) begin
                        q_n     = shift;
                        l_n     = 1'b1;
                        state_n = IDLE;
                    end else begin
                        fe_n    = 1'b1;
                        state_n = WAIT_IDLE;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            WAIT_IDLE: begin
                if (s) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset discards any partial frame.
    always_ff @(posedge C or negedge aRn) begin
        if (!aRn) begin
            state   <= IDLE;
            s_prev  <= 1'b1;
            cnt     <= '0;
            idx     <= '0;
            shift   <= '0;
            q_r     <= '0;
            l_r     <= 1'b0;
            fe_r    <= 1'b0;
            busy_r  <= 1'b0;
`ifdef NIBBLE_RX_PARITY_EN
            par_err <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            s_prev  <= s;
            cnt     <= cnt_n;
            idx     <= idx_n;
            shift   <= shift_n;
            q_r     <= q_n;
            l_r     <= l_n;
            fe_r    <= fe_n;
            busy_r  <= (state_n != IDLE);
`ifdef NIBBLE_RX_PARITY_EN
            par_err <= par_err_n;
`endif
        end
    end

    assign bus.Q    = q_r;
    assign bus.L    = l_r;
    assign bus.FE   = fe_r;
    assign bus.BUSY = busy_r;

endmodule

// File: tb/tb_nibble_rx_loader.sv
// Randomized frame-level bench for nibble_rx_loader (CLKS_PER_BIT=4, WIDTH=4).
// Honors NIBBLE_RX_PARITY_EN when the design is built with it.
module tb_nibble_rx_loader;
    localparam int CPB  = 4;
    localparam int W    = 4;
    localparam int TAIL = 5;
`ifdef NIBBLE_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    // SI fall to L: 2..3 cycles detect, half bit, then data/parity/stop bits.
    localparam int LAT_LO = 2 + CPB / 2 + (W + 1 + PB) * CPB;
    localparam int LAT_HI = LAT_LO + 1;

    logic clk = 1'b0;
    logic arn = 1'b0;

    nibble_rx_loader_if #(.WIDTH(W)) bus ();

    nibble_rx_loader #(.CLKS_PER_BIT(CPB), .WIDTH(W)) dut (
        .C   (clk),
        .aRn (arn),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int l_cnt    = 0;
    int fe_cnt   = 0;
    int busy_cnt = 0;
    int excl_bad = 0;
    int l_cyc    = 0;
    int fall_cyc = 0;
    logic [W-1:0] model_q;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse/occupancy monitor sampled on the inactive edge.
    always @(negedge clk) begin
        if (bus.L) begin
            l_cnt++;
            l_cyc = cyc;
        end
        if (bus.FE)            fe_cnt++;
        if (bus.BUSY)          busy_cnt++;
        if (bus.L && bus.FE)   excl_bad++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        bus.SI = b;
        tick(CPB);
    endtask

    // Send one frame and compare against the frame-level model.
    task automatic run_frame(input logic [W-1:0] data, input bit en_on, input bit en_drop,
                             input bit stop_bit, input bit par_bad, input int low_hold);
        int  l0, fe0, x0;
        bit  pb_err, exp_l, exp_fe;
        l0 = l_cnt; fe0 = fe_cnt; x0 = excl_bad;
        pb_err = (PB != 0) && par_bad;
        exp_l  = en_on && stop_bit && !pb_err;
        exp_fe = en_on && (!stop_bit || pb_err);

        bus.EN   = en_on;
        fall_cyc = cyc;
        drive_bit(1'b0);
        if (en_drop) bus.EN = 1'b0;
        for (int k = 0; k < W; k++) drive_bit(data[k]);
        if (PB != 0) drive_bit((^data) ^ par_bad);
        if (stop_bit) begin
            drive_bit(1'b1);
        end else begin
            bus.SI = 1'b0;
            tick(CPB + low_hold);
            if (exp_fe) check_eq("busy_hold_low", 32'(bus.BUSY), 32'd1);
            bus.SI = 1'b1;
        end
        tick(TAIL);
        bus.EN = 1'b1;

        if (exp_l) model_q = data;
        check_eq("l_count",  32'(l_cnt - l0),   32'(exp_l));
        check_eq("fe_count", 32'(fe_cnt - fe0), 32'(exp_fe));
        check_eq("q",        32'(bus.Q),        32'(model_q));
        check_eq("busy_end", 32'(bus.BUSY),     32'd0);
        check_eq("l_fe_excl", 32'(excl_bad - x0), 32'd0);
        if (exp_l)
            check_eq("l_latency", 32'((l_cyc - fall_cyc) >= LAT_LO && (l_cyc - fall_cyc) <= LAT_HI), 32'd1);
    endtask

    initial begin
        int l0, fe0, b0;
        model_q = '0;
        bus.SI  = 1'b1;
        bus.EN  = 1'b0;
        tick(3);
        check_eq("rst_q",    32'(bus.Q),    32'd0);
        check_eq("rst_l",    32'(bus.L),    32'd0);
        check_eq("rst_fe",   32'(bus.FE),   32'd0);
        check_eq("rst_busy", 32'(bus.BUSY), 32'd0);
        arn = 1'b1;
        tick(3);

        // Good frame 0xA.
        run_frame(4'hA, 1'b1, 1'b0, 1'b1, 1'b0, 0);

        // False start: one-cycle glitch low.
        l0 = l_cnt; fe0 = fe_cnt; b0 = busy_cnt;
        bus.SI = 1'b0;
        tick(1);
        bus.SI = 1'b1;
        tick(10);
        check_eq("fs_l",    32'(l_cnt - l0),    32'd0);
        check_eq("fs_fe",   32'(fe_cnt - fe0),  32'd0);
        check_eq("fs_q",    32'(bus.Q),         32'(model_q));
        check_eq("fs_busy", 32'(busy_cnt - b0), 32'(CPB / 2));

        // Framing error: stop low, line held low 20 cycles.
        run_frame(4'h5, 1'b1, 1'b0, 1'b0, 1'b0, 20);

        // EN gating: disabled for the whole frame, then dropped mid-frame.
        b0 = busy_cnt;
        run_frame(4'h3, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        check_eq("en_off_busy", 32'(busy_cnt - b0), 32'd0);
        run_frame(4'hC, 1'b1, 1'b1, 1'b1, 1'b0, 0);

        // Reset during DATA of 0xF, then a clean 0x6.
        l0 = l_cnt; fe0 = fe_cnt;
        bus.EN = 1'b1;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        #2 arn = 1'b0;
        #1;
        check_eq("mid_rst_q",    32'(bus.Q),    32'd0);
        check_eq("mid_rst_busy", 32'(bus.BUSY), 32'd0);
        check_eq("mid_rst_l",    32'(bus.L),    32'd0);
        model_q = '0;
        bus.SI = 1'b1;
        tick(3);
        arn = 1'b1;
        tick(6);
        check_eq("mid_rst_no_l",  32'(l_cnt - l0),   32'd0);
        check_eq("mid_rst_no_fe", 32'(fe_cnt - fe0), 32'd0);
        run_frame(4'h6, 1'b1, 1'b0, 1'b1, 1'b0, 0);

`ifdef NIBBLE_RX_PARITY_EN
        run_frame(4'h7, 1'b1, 1'b0, 1'b1, 1'b0, 0);
        run_frame(4'h7, 1'b1, 1'b0, 1'b1, 1'b1, 0);
`endif

        // Randomized frames.
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] d;
            d = W'($urandom_range(0, 15));
            run_frame(d,
                      ($urandom_range(0, 5) != 0),
                      ($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 4) != 0),
                      ($urandom_range(0, 4) == 0),
                      int'($urandom_range(0, 8)));
            tick(int'($urandom_range(0, 4)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
